// File: rtl/counter_monitor.sv
// counter_monitor: tracks an enable-gated up-counter, locks onto its sequence and reports skipped, stuck or corrupted counts.
module counter_monitor #(
   parameter int WIDTH         = 4,
   parameter int ERR_CNT_WIDTH = 8,
   parameter int SYNC_MATCHES  = 2
) (
   input  logic                     clock_i,
   input  logic                     reset_n_i,
   input  logic                     enable_i,
   input  logic [WIDTH-1:0]         counter_value_i,
   input  logic                     clear_i,
   output logic                     locked_o,
   output logic                     error_o,
   output logic                     wrap_o,
   output logic                     fault_o,
   output logic [ERR_CNT_WIDTH-1:0] error_count_o,
   output logic [1:0]               state_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;
   state_t                   state_q, state_d;
   logic [WIDTH-1:0]         prev_value_q, prev_value_d;
   logic                     prev_enable_q, prev_enable_d;
   logic [3:0]               match_cnt_q, match_cnt_d;
   logic                     fault_q, fault_d;
   logic                     error_q, error_d;
   logic                     wrap_q, wrap_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0]         exp_value;
   logic                     match;
   // carry out of the prediction is dropped so the all-ones to zero wrap is an ordinary match
   assign exp_value = prev_value_q + WIDTH'(prev_enable_q);
   assign match     = counter_value_i == exp_value;
   always_comb begin
      state_d       = state_q;
      prev_value_d  = counter_value_i;
      prev_enable_d = enable_i;
      match_cnt_d   = match_cnt_q;
      fault_d       = fault_q;
      err_cnt_d     = err_cnt_q;
      error_d       = 1'b0;
      wrap_d        = 1'b0;
      case (state_q)
         IDLE: begin
            state_d     = ACQUIRE;
            match_cnt_d = '0;
         end
         ACQUIRE: begin
            match_cnt_d = match ? match_cnt_q + 4'd1 : '0;
            state_d     = (match && match_cnt_d == 4'(SYNC_MATCHES)) ? LOCKED : ACQUIRE;
         end
         LOCKED: begin
            if (match) begin
               wrap_d = (&prev_value_q) & prev_enable_q;
            end else begin
               error_d     = 1'b1;
               fault_d     = 1'b1;
               err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_WIDTH'(1);
               match_cnt_d = '0;
               state_d     = ACQUIRE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (clear_i) begin
         state_d       = IDLE;
         prev_value_d  = '0;
         prev_enable_d = 1'b0;
         match_cnt_d   = '0;
         fault_d       = 1'b0;
         err_cnt_d     = '0;
         error_d       = 1'b0;
         wrap_d        = 1'b0;
      end
   end
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q       <= IDLE;
         prev_value_q  <= '0;
         prev_enable_q <= 1'b0;
         match_cnt_q   <= '0;
         fault_q       <= 1'b0;
         err_cnt_q     <= '0;
         error_q       <= 1'b0;
         wrap_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_value_q  <= prev_value_d;
         prev_enable_q <= prev_enable_d;
         match_cnt_q   <= match_cnt_d;
         fault_q       <= fault_d;
         err_cnt_q     <= err_cnt_d;
         error_q       <= error_d;
         wrap_q        <= wrap_d;
      end
   end
   assign locked_o      = state_q == LOCKED;
   assign error_o       = error_q;
   assign wrap_o        = wrap_q;
   assign fault_o       = fault_q;
   assign error_count_o = err_cnt_q;
   assign state_o       = state_q;
endmodule

// File: tb/tb_counter_monitor.sv
// tb_counter_monitor: directed checks of lock, wrap, enable gating, glitch, clear, reset and saturation behaviour.
module tb_counter_monitor;
   logic       clock_i = 1'b0;
   logic       reset_n_i, enable_i, clear_i;
   logic [3:0] counter_value_i;
   logic       locked_o, error_o, wrap_o, fault_o;
   logic [7:0] error_count_o;
   logic [1:0] state_o;
   int         n_cmp = 0, n_bad = 0;
   logic [3:0] cnt;

   always #5 clock_i = ~clock_i;

   counter_monitor dut (
      .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i),
      .counter_value_i(counter_value_i), .clear_i(clear_i), .locked_o(locked_o),
      .error_o(error_o), .wrap_o(wrap_o), .fault_o(fault_o),
      .error_count_o(error_count_o), .state_o(state_o)
   );

   task automatic tick(input logic [3:0] v, input logic e);
      counter_value_i = v;
      enable_i        = e;
      @(posedge clock_i);
      @(negedge clock_i);
   endtask

   task automatic step(input logic e);
      tick(cnt, e);
      cnt = cnt + {3'b000, e};
   endtask

   task automatic glitch_relock();
      tick(cnt + 4'd5, 1'b1);
      cnt = cnt + 4'd6;
      step(1'b1);
      step(1'b1);
   endtask

   task automatic test_reset();
      reset_n_i = 1'b0;
      clear_i   = 1'b0;
      @(negedge clock_i);
      tick(4'hA, 1'b1);
      tick(4'h3, 1'b0);
      n_cmp += 6;
      if (locked_o !== 1'b0)       begin $display("FAIL reset_locked got %0b want 0", locked_o); n_bad++; end
      if (error_o !== 1'b0)        begin $display("FAIL reset_error got %0b want 0", error_o); n_bad++; end
      if (wrap_o !== 1'b0)         begin $display("FAIL reset_wrap got %0b want 0", wrap_o); n_bad++; end
      if (fault_o !== 1'b0)        begin $display("FAIL reset_fault got %0b want 0", fault_o); n_bad++; end
      if (error_count_o !== 8'd0)  begin $display("FAIL reset_count got %0d want 0", error_count_o); n_bad++; end
      if (state_o !== 2'd0)        begin $display("FAIL reset_state got %0d want 0", state_o); n_bad++; end
   endtask

   task automatic test_lock_wrap();
      int wraps = 0, errs = 0, wrap_idx = -1;
      reset_n_i = 1'b1;
      cnt = 4'd0;
      step(1'b1);
      n_cmp++; if (state_o !== 2'd1) begin $display("FAIL lock_edge1_state got %0d want 1", state_o); n_bad++; end
      step(1'b1);
      n_cmp++; if (locked_o !== 1'b0) begin $display("FAIL lock_edge2_locked got %0b want 0", locked_o); n_bad++; end
      step(1'b1);
      n_cmp++; if (locked_o !== 1'b1) begin $display("FAIL lock_edge3_locked got %0b want 1", locked_o); n_bad++; end
      n_cmp++; if (state_o !== 2'd2) begin $display("FAIL lock_edge3_state got %0d want 2", state_o); n_bad++; end
      for (int i = 0; i < 16; i++) begin
         step(1'b1);
         if (wrap_o) begin wraps++; wrap_idx = i; end
         if (error_o) errs++;
      end
      n_cmp++; if (wraps != 1) begin $display("FAIL wrap_pulses got %0d want 1", wraps); n_bad++; end
      n_cmp++; if (wrap_idx != 13) begin $display("FAIL wrap_position got %0d want 13", wrap_idx); n_bad++; end
      n_cmp++; if (errs != 0) begin $display("FAIL wrap_errors got %0d want 0", errs); n_bad++; end
      n_cmp++; if (error_count_o !== 8'd0) begin $display("FAIL wrap_count got %0d want 0", error_count_o); n_bad++; end
      n_cmp++; if (fault_o !== 1'b0) begin $display("FAIL wrap_fault got %0b want 0", fault_o); n_bad++; end
   endtask

   task automatic test_enable_gating();
      logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         step(pat[i]);
         n_cmp++; if (locked_o !== 1'b1) begin $display("FAIL gate_locked step %0d got %0b want 1", i, locked_o); n_bad++; end
         n_cmp++; if (error_o !== 1'b0) begin $display("FAIL gate_error step %0d got %0b want 0", i, error_o); n_bad++; end
      end
   endtask

   task automatic test_glitch();
      tick(4'd9, 1'b1);
      cnt = 4'd7;
      n_cmp += 5;
      if (error_o !== 1'b1)       begin $display("FAIL glitch_error got %0b want 1", error_o); n_bad++; end
      if (error_count_o !== 8'd1) begin $display("FAIL glitch_count got %0d want 1", error_count_o); n_bad++; end
      if (fault_o !== 1'b1)       begin $display("FAIL glitch_fault got %0b want 1", fault_o); n_bad++; end
      if (locked_o !== 1'b0)      begin $display("FAIL glitch_locked got %0b want 0", locked_o); n_bad++; end
      if (state_o !== 2'd1)       begin $display("FAIL glitch_state got %0d want 1", state_o); n_bad++; end
      step(1'b1);
      n_cmp++; if (error_o !== 1'b0) begin $display("FAIL glitch_acq_error got %0b want 0", error_o); n_bad++; end
      step(1'b1);
      n_cmp++; if (locked_o !== 1'b0) begin $display("FAIL glitch_relock_early got %0b want 0", locked_o); n_bad++; end
      step(1'b1);
      n_cmp += 3;
      if (locked_o !== 1'b1)      begin $display("FAIL glitch_relock got %0b want 1", locked_o); n_bad++; end
      if (fault_o !== 1'b1)       begin $display("FAIL glitch_sticky_fault got %0b want 1", fault_o); n_bad++; end
      if (error_count_o !== 8'd1) begin $display("FAIL glitch_count_hold got %0d want 1", error_count_o); n_bad++; end
   endtask

   task automatic test_clear_priority();
      clear_i = 1'b1;
      tick(cnt + 4'd3, 1'b1);
      clear_i = 1'b0;
      n_cmp += 4;
      if (error_o !== 1'b0)       begin $display("FAIL clear_error got %0b want 0", error_o); n_bad++; end
      if (error_count_o !== 8'd0) begin $display("FAIL clear_count got %0d want 0", error_count_o); n_bad++; end
      if (fault_o !== 1'b0)       begin $display("FAIL clear_fault got %0b want 0", fault_o); n_bad++; end
      if (state_o !== 2'd0)       begin $display("FAIL clear_state got %0d want 0", state_o); n_bad++; end
      cnt = 4'd0;
      step(1'b1);
      step(1'b1);
      n_cmp++; if (locked_o !== 1'b0) begin $display("FAIL clear_relock_early got %0b want 0", locked_o); n_bad++; end
      step(1'b1);
      n_cmp++; if (locked_o !== 1'b1) begin $display("FAIL clear_relock got %0b want 1", locked_o); n_bad++; end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) glitch_relock();
      n_cmp += 2;
      if (error_count_o !== 8'd3) begin $display("FAIL rstmid_precount got %0d want 3", error_count_o); n_bad++; end
      if (locked_o !== 1'b1)      begin $display("FAIL rstmid_prelock got %0b want 1", locked_o); n_bad++; end
      reset_n_i = 1'b0;
      tick(4'($urandom_range(15)), 1'($urandom_range(1)));
      reset_n_i = 1'b1;
      n_cmp += 6;
      if (locked_o !== 1'b0)      begin $display("FAIL rstmid_locked got %0b want 0", locked_o); n_bad++; end
      if (error_o !== 1'b0)       begin $display("FAIL rstmid_error got %0b want 0", error_o); n_bad++; end
      if (wrap_o !== 1'b0)        begin $display("FAIL rstmid_wrap got %0b want 0", wrap_o); n_bad++; end
      if (fault_o !== 1'b0)       begin $display("FAIL rstmid_fault got %0b want 0", fault_o); n_bad++; end
      if (error_count_o !== 8'd0) begin $display("FAIL rstmid_count got %0d want 0", error_count_o); n_bad++; end
      if (state_o !== 2'd0)       begin $display("FAIL rstmid_state got %0d want 0", state_o); n_bad++; end
   endtask

   task automatic test_back_to_back();
      step(1'b1);
      step(1'b1);
      step(1'b1);
      tick(cnt + 4'd5, 1'b1);
      n_cmp += 2;
      if (error_o !== 1'b1)       begin $display("FAIL b2b_first_error got %0b want 1", error_o); n_bad++; end
      if (error_count_o !== 8'd1) begin $display("FAIL b2b_first_count got %0d want 1", error_count_o); n_bad++; end
      tick(cnt + 4'd9, 1'b1);
      n_cmp += 3;
      if (error_o !== 1'b0)       begin $display("FAIL b2b_second_error got %0b want 0", error_o); n_bad++; end
      if (error_count_o !== 8'd1) begin $display("FAIL b2b_second_count got %0d want 1", error_count_o); n_bad++; end
      if (state_o !== 2'd1)       begin $display("FAIL b2b_state got %0d want 1", state_o); n_bad++; end
      cnt = cnt + 4'd10;
      step(1'b1);
      step(1'b1);
      n_cmp++; if (locked_o !== 1'b1) begin $display("FAIL b2b_relock got %0b want 1", locked_o); n_bad++; end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 253; i++) glitch_relock();
      n_cmp++; if (error_count_o !== 8'd254) begin $display("FAIL sat_pre got %0d want 254", error_count_o); n_bad++; end
      for (int i = 0; i < 7; i++) glitch_relock();
      n_cmp += 2;
      if (error_count_o !== 8'd255) begin $display("FAIL sat_count got %0d want 255", error_count_o); n_bad++; end
      if (fault_o !== 1'b1)         begin $display("FAIL sat_fault got %0b want 1", fault_o); n_bad++; end
   endtask

   initial begin
      reset_n_i       = 1'b0;
      clear_i         = 1'b0;
      enable_i        = 1'b0;
      counter_value_i = 4'd0;
      test_reset();
      test_lock_wrap();
      test_enable_gating();
      test_glitch();
      test_clear_priority();
      test_reset_mid();
      test_back_to_back();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
